// File: rtl/data_bus_arbiter.sv
// Data-memory bus arbiter between the CPU D-cache and a DMA engine.
// DMA wins a free bus, but an in-flight CPU transaction is never preempted.
module data_bus_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              cpu_readM,
    input  logic                              cpu_writeM,
    input  logic [WORD_SIZE-1:0]              cpu_address,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]   cpu_wdata,
    output logic                              cpu_stall,
    output logic                              cpu_readyM,
    output logic                              cpu_doneM,
    input  logic                              BR,
    output logic                              BG,
    input  logic                              dma_writeM,
    input  logic [WORD_SIZE-1:0]              dma_address,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]   dma_wdata,
    output logic                              dma_doneM,
    output logic                              mem_readM,
    output logic                              mem_writeM,
    output logic [WORD_SIZE-1:0]              mem_address,
    output logic [LINE_WORDS*WORD_SIZE-1:0]   mem_wdata,
    input  logic                              mem_readyM,
    input  logic                              mem_doneM,
    output logic [WORD_SIZE-1:0]              num_grants,
    output logic [WORD_SIZE-1:0]              num_stolen
);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_BUSY,
        DMA_GRANT
    } state_t;

    localparam logic [WORD_SIZE-1:0] CNT_ONE = WORD_SIZE'(1);

    state_t               state_q, state_d;
    logic                 bg_q, bg_d;
    logic [WORD_SIZE-1:0] num_grants_q, num_grants_d;
    logic [WORD_SIZE-1:0] num_stolen_q, num_stolen_d;
    logic                 cpu_req;

    assign cpu_req    = cpu_readM | cpu_writeM;
    assign BG         = bg_q;
    assign num_grants = num_grants_q;
    assign num_stolen = num_stolen_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= CPU_IDLE;
            bg_q         <= 1'b0;
            num_grants_q <= '0;
            num_stolen_q <= '0;
        end else begin
            state_q      <= state_d;
            bg_q         <= bg_d;
            num_grants_q <= num_grants_d;
            num_stolen_q <= num_stolen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_grants_d = num_grants_q;
        num_stolen_d = num_stolen_q;
        cpu_stall    = 1'b0;
        cpu_readyM   = 1'b0;
        cpu_doneM    = 1'b0;
        dma_doneM    = 1'b0;
        mem_readM    = 1'b0;
        mem_writeM   = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;

        // Outputs are gated by reset_n itself because the reset is synchronous.
        if (reset_n) begin
            case (state_q)
                CPU_IDLE: begin
                    if (BR) begin
                        cpu_stall = cpu_req;
                        state_d   = DMA_GRANT;
                        if (num_grants_q != '1) num_grants_d = num_grants_q + CNT_ONE;
                    end else if (cpu_req) begin
                        mem_readM   = cpu_readM;
                        mem_writeM  = cpu_writeM & ~cpu_readM;
                        mem_address = cpu_address;
                        if (!cpu_readM) mem_wdata = cpu_wdata;
                        state_d = CPU_BUSY;
                    end
                end

                CPU_BUSY: begin
                    if (cpu_readM) begin
                        mem_readM   = 1'b1;
                        mem_address = cpu_address;
                        if (mem_readyM) begin
                            cpu_readyM = 1'b1;
                            state_d    = CPU_IDLE;
                        end
                    end else if (cpu_writeM) begin
                        mem_writeM  = 1'b1;
                        mem_address = cpu_address;
                        mem_wdata   = cpu_wdata;
                        if (mem_doneM) begin
                            cpu_doneM = 1'b1;
                            state_d   = CPU_IDLE;
                        end
                    end else begin
                        // Request withdrawn: free the bus rather than wait forever.
                        state_d = CPU_IDLE;
                    end
                end

                DMA_GRANT: begin
                    mem_writeM = dma_writeM;
                    if (dma_writeM) begin
                        mem_address = dma_address;
                        mem_wdata   = dma_wdata;
                    end
                    dma_doneM = mem_doneM;
                    cpu_stall = cpu_req;
                    if (cpu_req && num_stolen_q != '1) num_stolen_d = num_stolen_q + CNT_ONE;
                    if (!BR) state_d = CPU_IDLE;
                end

                default: state_d = CPU_IDLE;
            endcase
        end

        bg_d = (state_d == DMA_GRANT);
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: vector table, directed corner
// sequences, and randomized traffic against a rule-level reference model.
module tb_data_bus_arbiter;

    localparam int WS = 16;
    localparam int LW = 64;
    localparam logic [WS-1:0] CPU_A  = 16'h0040;
    localparam logic [WS-1:0] DMA_A  = 16'h01F0;
    localparam logic [LW-1:0] CPU_WD = 64'hC0C0_1111_2222_3333;
    localparam logic [LW-1:0] DMA_WD = 64'hD0D0_4444_5555_6666;
    localparam int CMAX = 65535;

    logic          clk;
    logic          reset_n, cpu_readM, cpu_writeM, BR, dma_writeM, mem_readyM, mem_doneM;
    logic [WS-1:0] cpu_address, dma_address;
    logic [LW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_stall, cpu_readyM, cpu_doneM, BG, dma_doneM, mem_readM, mem_writeM;
    logic [WS-1:0] mem_address, num_grants, num_stolen;
    logic [LW-1:0] mem_wdata;

    // Narrow instance used only to reach counter saturation quickly.
    logic       s_reset_n, s_rd, s_br;
    logic       s_stall, s_rdy, s_done, s_bg, s_dd, s_mrd, s_mwr;
    logic [3:0] s_addr, s_wd, s_grants, s_stolen;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_bus_arbiter #(.WORD_SIZE(WS), .LINE_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_readyM(cpu_readyM),
        .cpu_doneM(cpu_doneM), .BR(BR), .BG(BG), .dma_writeM(dma_writeM),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_doneM(dma_doneM),
        .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_readyM(mem_readyM), .mem_doneM(mem_doneM),
        .num_grants(num_grants), .num_stolen(num_stolen)
    );

    data_bus_arbiter #(.WORD_SIZE(4), .LINE_WORDS(1)) dut_sat (
        .clk(clk), .reset_n(s_reset_n),
        .cpu_readM(s_rd), .cpu_writeM(1'b0), .cpu_address(4'h3),
        .cpu_wdata(4'h5), .cpu_stall(s_stall), .cpu_readyM(s_rdy),
        .cpu_doneM(s_done), .BR(s_br), .BG(s_bg), .dma_writeM(1'b0),
        .dma_address(4'h9), .dma_wdata(4'hA), .dma_doneM(s_dd),
        .mem_readM(s_mrd), .mem_writeM(s_mwr), .mem_address(s_addr),
        .mem_wdata(s_wd), .mem_readyM(1'b0), .mem_doneM(1'b0),
        .num_grants(s_grants), .num_stolen(s_stolen)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst, rd, wr, br, dwr, rdy, done);
        @(negedge clk);
        reset_n = rst; cpu_readM = rd; cpu_writeM = wr; BR = br;
        dma_writeM = dwr; mem_readyM = rdy; mem_doneM = done;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [86:0] obs();
        return {cpu_stall, mem_readM, mem_writeM, cpu_readyM, cpu_doneM, dma_doneM, BG,
                mem_address, mem_wdata};
    endfunction

    typedef struct {
        logic          rst, rd, wr, br, dwr, rdy, done;
        logic [6:0]    flags;   // {stall, mrd, mwr, rdy, done, dma_done, bg}
        logic [WS-1:0] addr;
        logic [1:0]    wsel;    // 0: zero, 1: cpu line, 2: dma line
    } vec_t;

    function automatic vec_t mk(input logic rst, rd, wr, br, dwr, rdy, done,
                                input logic [6:0] flags, input logic [WS-1:0] addr,
                                input logic [1:0] wsel);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.br = br; v.dwr = dwr; v.rdy = rdy; v.done = done;
        v.flags = flags; v.addr = addr; v.wsel = wsel;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        logic [LW-1:0] wexp;
        int            pulses, seen_rd;
        bit            m_bg, m_busy;
        int            m_gr, m_st;

        reset_n = 0; cpu_readM = 0; cpu_writeM = 0; BR = 0; dma_writeM = 0;
        mem_readyM = 0; mem_doneM = 0;
        cpu_address = CPU_A; dma_address = DMA_A; cpu_wdata = CPU_WD; dma_wdata = DMA_WD;
        s_reset_n = 0; s_rd = 0; s_br = 0;
        repeat (2) @(posedge clk);

        // Read with 3-cycle memory latency, then a DMA grant with stolen cycles.
        tbl[0]  = mk(0,0,0,0,0,0,0, 7'b0000000, '0,    0);
        tbl[1]  = mk(0,1,0,0,0,0,0, 7'b0000000, '0,    0);
        tbl[2]  = mk(1,1,0,0,0,0,0, 7'b0100000, CPU_A, 0);
        tbl[3]  = mk(1,1,0,0,0,0,0, 7'b0100000, CPU_A, 0);
        tbl[4]  = mk(1,1,0,0,0,0,0, 7'b0100000, CPU_A, 0);
        tbl[5]  = mk(1,1,0,0,0,1,0, 7'b0101000, CPU_A, 0);
        tbl[6]  = mk(1,0,0,0,0,0,0, 7'b0000000, '0,    0);
        tbl[7]  = mk(1,0,0,1,0,0,0, 7'b0000000, '0,    0);
        tbl[8]  = mk(1,0,0,1,1,0,0, 7'b0010001, DMA_A, 2);
        tbl[9]  = mk(1,0,0,1,1,0,1, 7'b0010011, DMA_A, 2);
        tbl[10] = mk(1,1,0,1,0,0,0, 7'b1000001, '0,    0);
        tbl[11] = mk(1,1,0,0,0,0,0, 7'b1000001, '0,    0);
        tbl[12] = mk(1,1,0,0,0,0,0, 7'b0100000, CPU_A, 0);
        tbl[13] = mk(1,1,0,0,0,1,0, 7'b0101000, CPU_A, 0);
        tbl[14] = mk(1,0,0,0,0,0,0, 7'b0000000, '0,    0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].br, tbl[i].dwr, tbl[i].rdy, tbl[i].done);
            wexp = (tbl[i].wsel == 2'd1) ? CPU_WD : (tbl[i].wsel == 2'd2) ? DMA_WD : '0;
            chk($sformatf("vec%0d", i), 128'(obs()), 128'({tbl[i].flags, tbl[i].addr, wexp}));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("vec_counters", 128'({num_grants, num_stolen}), 128'({16'd1, 16'd2}));

        // Three DMA line writes, then BR falls.
        do_reset();
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("dma3_bg_before", 128'(BG), 128'(0));
        pulses = 0;
        for (int l = 0; l < 3; l++) begin
            dma_address = 16'h01F0 + 16'(4 * l);
            drive(1, 0, 0, 1, 1, 0, 0);
            chk($sformatf("dma3_req%0d", l), 128'({BG, mem_writeM, mem_readM, mem_address}),
                128'({1'b1, 1'b1, 1'b0, 16'h01F0 + 16'(4 * l)}));
            pulses += int'(dma_doneM);
            drive(1, 0, 0, 1, 1, 0, 1);
            pulses += int'(dma_doneM);
        end
        chk("dma3_pulses", 128'(pulses), 128'(3));
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("dma3_bg_at_fall", 128'(BG), 128'(1));
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("dma3_bg_after", 128'(BG), 128'(0));
        chk("dma3_grants", 128'(num_grants), 128'(1));
        dma_address = DMA_A;

        // BR raised while a CPU write is in flight.
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("wr_fwd", 128'({mem_writeM, cpu_stall, mem_wdata}), 128'({1'b1, 1'b0, CPU_WD}));
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("wr_hold_bg", 128'({BG, mem_writeM}), 128'({1'b0, 1'b1}));
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("wr_hold_bg2", 128'({BG, mem_writeM}), 128'({1'b0, 1'b1}));
        drive(1, 0, 1, 1, 0, 0, 1);
        chk("wr_done", 128'({BG, cpu_doneM, dma_doneM}), 128'({1'b0, 1'b1, 1'b0}));
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("wr_idle_bg", 128'(BG), 128'(0));
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("wr_then_grant", 128'(BG), 128'(1));
        drive(1, 0, 0, 0, 0, 0, 0);

        // Read and BR in the same idle cycle; grant held 10 cycles.
        do_reset();
        drive(1, 1, 0, 1, 0, 0, 0);
        chk("steal_block", 128'({cpu_stall, mem_readM, BG}), 128'({1'b1, 1'b0, 1'b0}));
        seen_rd = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 0, (c < 9) ? 1'b1 : 1'b0, 0, 0, 0);
            seen_rd += int'(mem_readM);
            if (c == 9) chk("steal_last_bg", 128'({BG, cpu_stall}), 128'({1'b1, 1'b1}));
        end
        chk("steal_no_read", 128'(seen_rd), 128'(0));
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("steal_fwd", 128'({BG, mem_readM, cpu_stall, mem_address}),
            128'({1'b0, 1'b1, 1'b0, CPU_A}));
        chk("steal_count", 128'(num_stolen), 128'(10));
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset during a DMA grant with a completion pending.
        do_reset();
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        chk("rstg_bg", 128'(BG), 128'(1));
        drive(0, 1, 0, 1, 1, 0, 1);
        chk("rstg_quiet", 128'({dma_doneM, mem_writeM, mem_readM, cpu_stall, mem_address}), 128'(0));
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("rstg_after", 128'({BG, num_grants, num_stolen, mem_readM}), 128'({1'b0, 32'd0, 1'b1}));
        drive(1, 1, 0, 0, 0, 1, 0);
        chk("rstg_read_done", 128'({cpu_readyM, dma_doneM}), 128'({1'b1, 1'b0}));
        drive(1, 0, 0, 0, 0, 0, 0);

        // Simultaneous read and write: read wins.
        do_reset();
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("rw_fwd", 128'({mem_readM, mem_writeM}), 128'({1'b1, 1'b0}));
        drive(1, 1, 1, 0, 0, 0, 1);
        chk("rw_no_wdone", 128'({cpu_doneM, cpu_readyM}), 128'(0));
        drive(1, 1, 1, 0, 0, 1, 0);
        chk("rw_rdy", 128'({cpu_readyM, cpu_doneM}), 128'({1'b1, 1'b0}));
        drive(1, 0, 0, 0, 0, 0, 0);

        // Counter saturation on the 4-bit instance: 20 grants, 20 stolen cycles.
        @(negedge clk); s_reset_n = 0; s_rd = 0; s_br = 0;
        @(negedge clk); s_reset_n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); s_br = 1; s_rd = 1;
            @(negedge clk); s_br = 1; s_rd = 1;
            @(negedge clk); s_br = 0; s_rd = 0;
        end
        @(negedge clk); #1;
        chk("sat_counts", 128'({s_grants, s_stolen}), 128'({4'hF, 4'hF}));

        // Randomized traffic against a rule-level model.
        m_bg = 0; m_busy = 0; m_gr = 0; m_st = 0;
        for (int n = 0; n < 2500; n++) begin
            logic          rst, rd, wr, br, dwr, rdy, dn, req;
            logic          e_st, e_mrd, e_mwr, e_rdy, e_dn, e_dd;
            logic [WS-1:0] e_a;
            logic [LW-1:0] e_wd;
            rst = (n < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
            rd  = ($urandom_range(0, 2) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            br  = BR ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 6) == 0);
            dwr = ($urandom_range(0, 1) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            dn  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            cpu_address = 16'($urandom); dma_address = 16'($urandom);
            cpu_wdata = {$urandom, $urandom}; dma_wdata = {$urandom, $urandom};
            reset_n = rst; cpu_readM = rd; cpu_writeM = wr; BR = br;
            dma_writeM = dwr; mem_readyM = rdy; mem_doneM = dn;
            #1;
            req = rd | wr;
            {e_st, e_mrd, e_mwr, e_rdy, e_dn, e_dd} = '0;
            e_a = '0; e_wd = '0;
            if (rst) begin
                if (m_bg) begin
                    e_st = req; e_mwr = dwr; e_dd = dn;
                    if (dwr) begin e_a = dma_address; e_wd = dma_wdata; end
                end else if (m_busy || !br) begin
                    if (rd) begin
                        e_mrd = 1; e_a = cpu_address;
                    end else if (wr) begin
                        e_mwr = 1; e_a = cpu_address; e_wd = cpu_wdata;
                    end
                    if (m_busy) begin
                        e_rdy = rd & rdy;
                        e_dn  = ~rd & wr & dn;
                    end
                end else begin
                    e_st = req;
                end
            end
            chk($sformatf("rnd%0d_out", n), 128'(obs()),
                128'({e_st, e_mrd, e_mwr, e_rdy, e_dn, e_dd, m_bg, e_a, e_wd}));
            chk($sformatf("rnd%0d_cnt", n), 128'({num_grants, num_stolen}),
                128'({16'(m_gr), 16'(m_st)}));
            if (!rst) begin
                m_bg = 0; m_busy = 0; m_gr = 0; m_st = 0;
            end else if (m_bg) begin
                if (req && m_st < CMAX) m_st++;
                if (!br) m_bg = 0;
            end else if (m_busy) begin
                if (e_rdy || e_dn || !req) m_busy = 0;
            end else if (br) begin
                m_bg = 1;
                if (m_gr < CMAX) m_gr++;
            end else if (req) begin
                m_busy = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
